shadow_unpack: RTL and testbench

Downstream consumer of the shadow capture stage: accepts the serial capture stream (one bit per `bit_valid` strobe) and packs it LSB-first into `WORD_W`-bit words. Words are buffered in a small show-ahead FIFO and presented on a valid/ready port to the readout logic. Because the capture stage has no backpressure input, this block owns frame framing, last-word padding, idle timeout and overflow reporting.

---
 rtl/shadow_unpack.sv | 177 +++++++++++++++++
 tb/tb_shadow_unpack.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/shadow_unpack.sv
// Serial-to-word unpacker for the shadow capture stream: LSB-first packing,
// frame/timeout framing and a show-ahead word FIFO with overflow reporting.
module shadow_unpack #(
  parameter int unsigned WORD_W     = 8,
  parameter int unsigned FRAME_BITS = 64,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_start,
  input  logic [0:0]        bit_in,
  input  logic              bit_valid,
  output logic [WORD_W-1:0] word_out,
  output logic              word_last,
  output logic              word_valid,
  input  logic              word_ready,
  output logic              busy,
  output logic              overflow,
  output logic              timeout
);

  localparam int unsigned WPW = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int unsigned FBW = $clog2(FRAME_BITS + 1);
  localparam int unsigned IW  = $clog2(TIMEOUT + 1);
  localparam int unsigned PW  = $clog2(FIFO_DEPTH);

  localparam logic [WPW-1:0] WPOS_LAST = WPW'(WORD_W - 1);
  localparam logic [FBW-1:0] BIT_LAST  = FBW'(FRAME_BITS - 1);
  localparam logic [IW-1:0]  IDLE_LAST = IW'(TIMEOUT - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t            state_q, state_d;
  logic [FBW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [WPW-1:0]    wpos_q, wpos_d;
  logic [WORD_W-1:0] sreg_q, sreg_d;
  logic [IW-1:0]     idle_q, idle_d;
  logic [WORD_W-1:0] word_ins;
  logic              flag_clr;
  logic              set_timeout;
  logic              push;
  logic [WORD_W-1:0] push_word;
  logic              push_last;

  logic [WORD_W-1:0] data_mem [FIFO_DEPTH];
  logic              last_mem [FIFO_DEPTH];
  logic [PW:0]       wr_q, rd_q;
  logic              fifo_empty, fifo_full;
  logic              pop, do_push, drop;
  logic              overflow_q, timeout_q;

  // Pending partial word is tracked by wpos alone: whole words leave sreg empty.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    wpos_d      = wpos_q;
    sreg_d      = sreg_q;
    idle_d      = idle_q;
    flag_clr    = 1'b0;
    set_timeout = 1'b0;
    push        = 1'b0;
    push_word   = '0;
    push_last   = 1'b0;
    word_ins         = sreg_q;
    word_ins[wpos_q] = bit_in[0];

    unique case (state_q)
      IDLE: begin
        if (frame_start) begin
          state_d   = SHIFT;
          bit_cnt_d = '0;
          wpos_d    = '0;
          sreg_d    = '0;
          idle_d    = '0;
          flag_clr  = 1'b1;
        end
      end
      SHIFT: begin
        if (frame_start) begin
          bit_cnt_d = '0;
          wpos_d    = '0;
          sreg_d    = '0;
          idle_d    = '0;
          flag_clr  = 1'b1;
        end else if (bit_valid) begin
          idle_d = '0;
          if (bit_cnt_q == BIT_LAST) begin
            push      = 1'b1;
            push_word = word_ins;
            push_last = 1'b1;
            state_d   = IDLE;
            bit_cnt_d = '0;
            wpos_d    = '0;
            sreg_d    = '0;
          end else if (wpos_q == WPOS_LAST) begin
            push      = 1'b1;
            push_word = word_ins;
            bit_cnt_d = bit_cnt_q + 1'b1;
            wpos_d    = '0;
            sreg_d    = '0;
          end else begin
            sreg_d    = word_ins;
            wpos_d    = wpos_q + 1'b1;
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else if (idle_q == IDLE_LAST) begin
          if (wpos_q != '0) begin
            push      = 1'b1;
            push_word = sreg_q;
            push_last = 1'b1;
          end
          set_timeout = 1'b1;
          state_d     = IDLE;
          bit_cnt_d   = '0;
          wpos_d      = '0;
          sreg_d      = '0;
          idle_d      = '0;
        end else begin
          idle_d = idle_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign fifo_empty = (wr_q == rd_q);
  assign fifo_full  = (wr_q[PW] != rd_q[PW]) && (wr_q[PW-1:0] == rd_q[PW-1:0]);
  assign pop        = !fifo_empty && word_ready;
  assign do_push    = push && (!fifo_full || pop);
  assign drop       = push && fifo_full && !pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      wpos_q     <= '0;
      sreg_q     <= '0;
      idle_q     <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      overflow_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      wpos_q    <= wpos_d;
      sreg_q    <= sreg_d;
      idle_q    <= idle_d;
      if (do_push) wr_q <= wr_q + 1'b1;
      if (pop)     rd_q <= rd_q + 1'b1;
      if (flag_clr)  overflow_q <= 1'b0;
      else if (drop) overflow_q <= 1'b1;
      if (flag_clr)         timeout_q <= 1'b0;
      else if (set_timeout) timeout_q <= 1'b1;
    end
  end

  // Storage needs no reset: the head is masked to zero while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (!rst && do_push) begin
      data_mem[wr_q[PW-1:0]] <= push_word;
      last_mem[wr_q[PW-1:0]] <= push_last;
    end
  end

  assign word_valid = !fifo_empty;
  assign word_out   = fifo_empty ? '0 : data_mem[rd_q[PW-1:0]];
  assign word_last  = fifo_empty ? 1'b0 : last_mem[rd_q[PW-1:0]];
  assign busy       = (state_q == SHIFT);
  assign overflow   = overflow_q;
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_shadow_unpack.sv
// Directed bench for shadow_unpack: a default instance (64-bit frames) and a
// short-frame, short-timeout instance driven from a vector table.
module tb_shadow_unpack;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       a_fs = 0, a_bv = 0, a_rdy = 0;
  logic [0:0] a_bi = '0;
  logic [7:0] a_wo;
  logic       a_wl, a_wv, a_busy, a_ovf, a_to;

  logic       b_fs = 0, b_bv = 0, b_rdy = 0;
  logic [0:0] b_bi = '0;
  logic [7:0] b_wo;
  logic       b_wl, b_wv, b_busy, b_ovf, b_to;

  shadow_unpack u_a (
    .clk(clk), .rst(rst), .frame_start(a_fs), .bit_in(a_bi), .bit_valid(a_bv),
    .word_out(a_wo), .word_last(a_wl), .word_valid(a_wv), .word_ready(a_rdy),
    .busy(a_busy), .overflow(a_ovf), .timeout(a_to)
  );

  shadow_unpack #(.WORD_W(8), .FRAME_BITS(12), .FIFO_DEPTH(4), .TIMEOUT(10)) u_b (
    .clk(clk), .rst(rst), .frame_start(b_fs), .bit_in(b_bi), .bit_valid(b_bv),
    .word_out(b_wo), .word_last(b_wl), .word_valid(b_wv), .word_ready(b_rdy),
    .busy(b_busy), .overflow(b_ovf), .timeout(b_to)
  );

  typedef struct {
    logic       fs, bv, bi, rdy;
    logic       wv, wl, busy, ovf, to;
    logic [7:0] wo;
  } vec_t;

  vec_t vt[$];
  int total = 0;
  int bad   = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t row(input logic fs, bv, bi, rdy, wv, input logic [7:0] wo,
                               input logic wl, busy, ovf, to);
    vec_t v;
    v.fs = fs; v.bv = bv; v.bi = bi; v.rdy = rdy;
    v.wv = wv; v.wo = wo; v.wl = wl; v.busy = busy; v.ovf = ovf; v.to = to;
    return v;
  endfunction

  function automatic logic pat(input int i);
    return (i % 3) == 0;
  endfunction

  function automatic logic [7:0] exp_word(input int k);
    logic [7:0] w;
    for (int b = 0; b < 8; b++) w[b] = pat(8 * k + b);
    return w;
  endfunction

  function automatic logic [12:0] a_pack();
    return {a_wv, a_wl, a_busy, a_ovf, a_to, a_wo};
  endfunction

  function automatic logic [12:0] b_pack();
    return {b_wv, b_wl, b_busy, b_ovf, b_to, b_wo};
  endfunction

  task automatic a_bit(input logic b);
    a_bv = 1'b1;
    a_bi = b;
    tick();
    a_bv = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] words[$];
    logic       lasts[$];
    logic [0:0] abort_bits [7];
    int n;

    // ---- vector table for the 12-bit-frame instance ----
    vt.push_back(row(1,0,0,0, 0,8'h00,0,1,0,0));
    for (int i = 0; i < 7; i++) vt.push_back(row(0,1,1,0, 0,8'h00,0,1,0,0));
    for (int i = 0; i < 4; i++) vt.push_back(row(0,1,1,0, 1,8'hFF,0,1,0,0));
    vt.push_back(row(0,1,1,0, 1,8'hFF,0,0,0,0));
    vt.push_back(row(0,1,0,0, 1,8'hFF,0,0,0,0));
    vt.push_back(row(0,0,0,1, 1,8'h0F,1,0,0,0));
    vt.push_back(row(0,0,0,1, 0,8'h00,0,0,0,0));
    vt.push_back(row(1,0,0,0, 0,8'h00,0,1,0,0));
    for (int i = 0; i < 5; i++) vt.push_back(row(0,1,1,0, 0,8'h00,0,1,0,0));
    vt.push_back(row(1,1,1,0, 0,8'h00,0,1,0,0));
    abort_bits = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 7; i++) vt.push_back(row(0,1,abort_bits[i],0, 0,8'h00,0,1,0,0));
    vt.push_back(row(0,1,1,0, 1,8'h85,0,1,0,0));
    vt.push_back(row(0,0,0,1, 0,8'h00,0,1,0,0));
    for (int i = 0; i < 8; i++) vt.push_back(row(0,0,0,0, 0,8'h00,0,1,0,0));
    vt.push_back(row(0,0,0,0, 0,8'h00,0,0,0,1));

    // ---- reset ----
    rst = 1'b1;
    tick();
    tick();
    chk("a_reset", a_pack(), 13'h0);
    chk("b_reset", b_pack(), 13'h0);
    rst = 1'b0;

    // ---- table-driven run on short-frame instance ----
    foreach (vt[i]) begin
      b_fs = vt[i].fs; b_bv = vt[i].bv; b_bi = vt[i].bi; b_rdy = vt[i].rdy;
      tick();
      b_fs = 1'b0; b_bv = 1'b0;
      chk($sformatf("vec[%0d]", i), b_pack(),
          {vt[i].wv, vt[i].wl, vt[i].busy, vt[i].ovf, vt[i].to, vt[i].wo});
    end

    // ---- timeout with a 3-bit partial word ----
    b_rdy = 1'b0;
    b_fs = 1'b1; tick(); b_fs = 1'b0;
    chk("b_to_fs_clears", {b_busy, b_to}, 2'b10);
    for (int i = 0; i < 3; i++) begin
      b_bv = 1'b1; b_bi = 1'b1; tick();
    end
    b_bv = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    chk("b_to_pre", {b_wv, b_busy, b_to}, 3'b010);
    tick();
    chk("b_to_push", b_pack(), {1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h07});
    b_rdy = 1'b1; tick();
    chk("b_to_drain", b_wv, 1'b0);
    b_rdy = 1'b0;

    // ---- continuous 64-bit frame, consumer always ready ----
    a_rdy = 1'b1;
    a_fs = 1'b1; tick(); a_fs = 1'b0;
    chk("t1_busy_start", a_busy, 1'b1);
    for (int i = 0; i < 64; i++) begin
      a_bv = 1'b1; a_bi = pat(i);
      tick();
      if (a_wv) begin
        words.push_back(a_wo);
        lasts.push_back(a_wl);
      end
      if (i == 62) chk("t1_busy_b62", a_busy, 1'b1);
      if (i == 63) chk("t1_busy_b63", a_busy, 1'b0);
    end
    a_bv = 1'b0;
    tick();
    chk("t1_count", words.size(), 8);
    chk("t1_word0", (words.size() > 0) ? words[0] : 8'hxx, 8'h49);
    for (int k = 0; k < words.size() && k < 8; k++) begin
      chk($sformatf("t1_word%0d", k), words[k], exp_word(k));
      chk($sformatf("t1_last%0d", k), lasts[k], (k == 7));
    end
    chk("t1_ovf", a_ovf, 1'b0);

    // ---- consumer stalled: overflow after the FIFO fills ----
    words.delete(); lasts.delete();
    a_rdy = 1'b0;
    a_fs = 1'b1; tick(); a_fs = 1'b0;
    for (int i = 0; i < 64; i++) begin
      a_bit(pat(i));
      if (i == 31) chk("t3_full_no_ovf", {a_wv, a_ovf}, 2'b10);
      if (i == 39) chk("t3_ovf_set", a_ovf, 1'b1);
    end
    chk("t3_idle", a_busy, 1'b0);
    a_rdy = 1'b1;
    n = 0;
    while (a_wv && n < 10) begin
      words.push_back(a_wo);
      lasts.push_back(a_wl);
      n++;
      tick();
    end
    chk("t3_count", words.size(), 4);
    for (int k = 0; k < words.size() && k < 4; k++) begin
      chk($sformatf("t3_word%0d", k), words[k], exp_word(k));
      chk($sformatf("t3_last%0d", k), lasts[k], 1'b0);
    end
    chk("t3_ovf_sticky", a_ovf, 1'b1);

    // ---- full FIFO, push and pop on the same edge ----
    words.delete(); lasts.delete();
    a_rdy = 1'b0;
    a_fs = 1'b1; tick(); a_fs = 1'b0;
    chk("t5_fs_clears_ovf", a_ovf, 1'b0);
    for (int i = 0; i < 39; i++) a_bit(pat(i));
    a_rdy = 1'b1;
    a_bit(pat(39));
    a_rdy = 1'b0;
    chk("t5_no_ovf", a_ovf, 1'b0);
    chk("t5_head", a_wo, exp_word(1));
    a_rdy = 1'b1;
    n = 0;
    while (a_wv && n < 10) begin
      words.push_back(a_wo);
      n++;
      tick();
    end
    a_rdy = 1'b0;
    chk("t5_count", words.size(), 4);
    for (int k = 0; k < words.size() && k < 4; k++)
      chk($sformatf("t5_word%0d", k), words[k], exp_word(k + 1));

    // ---- reset mid-frame ----
    a_fs = 1'b1; tick(); a_fs = 1'b0;
    for (int i = 0; i < 20; i++) a_bit(pat(i));
    chk("t6_pre_rst", {a_wv, a_busy}, 2'b11);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("t6_after_rst", a_pack(), 13'h0);
    for (int i = 0; i < 5; i++) a_bit(1'b1);
    chk("t6_bits_ignored", {a_wv, a_busy}, 2'b00);
    a_fs = 1'b1; tick(); a_fs = 1'b0;
    for (int i = 0; i < 8; i++) a_bit(1'b1);
    chk("t6_new_frame", {a_wv, a_wl, a_wo}, {1'b1, 1'b0, 8'hFF});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
